// File: rtl/seq_trace_pkg.sv
// Shared definitions for the loop-sequencer trace checker.
//   - Legal state codes of the upstream loop sequencer (0 -> 2 -> 6 -> 3 -> 0).
//   - Error cause encoding reported on err_code.
//   - Checker FSM state encoding.
package seq_trace_pkg;

    localparam logic [2:0] ST_0 = 3'd0;
    localparam logic [2:0] ST_2 = 3'd2;
    localparam logic [2:0] ST_6 = 3'd6;
    localparam logic [2:0] ST_3 = 3'd3;

    typedef enum logic [1:0] {
        E_NONE    = 2'd0,
        E_FLAG    = 2'd1,
        E_ILLEGAL = 2'd2,
        E_SEQ     = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } chk_state_e;

endpackage

// File: rtl/seq_trace_succ.sv
// Successor lookup for the loop sequencer.
// Ports:
//   st_code   in  3  observed state code
//   legal     out 1  code belongs to the legal loop
//   succ_code out 3  required next code when legal (0 otherwise)
// Isolated so alternative successor tables can be dropped in.
module seq_trace_succ
    import seq_trace_pkg::*;
(
    input  logic [2:0] st_code,
    output logic       legal,
    output logic [2:0] succ_code
);

    always_comb begin
        legal     = 1'b1;
        succ_code = ST_0;
        case (st_code)
            ST_0:    succ_code = ST_2;
            ST_2:    succ_code = ST_6;
            ST_6:    succ_code = ST_3;
            ST_3:    succ_code = ST_0;
            default: legal     = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_trace_checker.sv
// On-chip observer of the 3-bit loop sequencer. Checks every valid sample
// against the successor table, latches a sticky error with its first cause,
// counts completed loops (saturating) and pulses loop_done per loop.
// Optional feature macro: SEQ_TRACE_STUTTER_EN -- when defined, a valid
// sample repeating the previously accepted code is accepted silently.
// Ports:
//   clk       in  1      rising-edge clock
//   reset     in  1      synchronous active-high reset
//   in_vld    in  1      sample qualifier
//   st_code   in  3      upstream state code
//   flag      in  1      upstream bad-state flag, must never be 1
//   armed     out 1      tracking after seeing code 0
//   err       out 1      sticky error
//   err_code  out 2      0 NONE, 1 FLAG, 2 ILLEGAL, 3 SEQ
//   loop_cnt  out CNT_W  completed loops, saturating
//   loop_done out 1      one-cycle pulse per completed loop
module seq_trace_checker
    import seq_trace_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [2:0]       st_code,
    input  logic             flag,
    output logic             armed,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] loop_cnt,
    output logic             loop_done
);

    chk_state_e       state_q, state_n;
    err_code_e        ecode_q, ecode_n;
    logic [2:0]       exp_q, exp_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             done_n;
    logic             legal;
    logic [2:0]       succ_code;
`ifdef SEQ_TRACE_STUTTER_EN
    logic [2:0]       prev_q, prev_n;
`endif

    seq_trace_succ u_succ (
        .st_code   (st_code),
        .legal     (legal),
        .succ_code (succ_code)
    );

    always_comb begin
        state_n = state_q;
        ecode_n = ecode_q;
        exp_n   = exp_q;
        cnt_n   = cnt_q;
        done_n  = 1'b0;
`ifdef SEQ_TRACE_STUTTER_EN
        prev_n  = prev_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_vld) begin
                    if (flag) begin
                        state_n = ERR;
                        ecode_n = E_FLAG;
                    end else if (st_code == ST_0) begin
                        // Arming zero starts tracking but is not a completed loop.
                        state_n = TRACK;
                        exp_n   = ST_2;
`ifdef SEQ_TRACE_STUTTER_EN
                        prev_n  = ST_0;
`endif
                    end
                end
            end
            TRACK: begin
                if (in_vld) begin
                    if (flag) begin
                        state_n = ERR;
                        ecode_n = E_FLAG;
                    end else if (!legal) begin
                        state_n = ERR;
                        ecode_n = E_ILLEGAL;
`ifdef SEQ_TRACE_STUTTER_EN
                    end else if (st_code == prev_q) begin
                        // Stutter: repeated code accepted, nothing advances.
                        state_n = TRACK;
`endif
                    end else if (st_code != exp_q) begin
                        state_n = ERR;
                        ecode_n = E_SEQ;
                    end else begin
                        exp_n = succ_code;
`ifdef SEQ_TRACE_STUTTER_EN
                        prev_n = st_code;
`endif
                        if (st_code == ST_0) begin
                            done_n = 1'b1;
                            if (cnt_q != {CNT_W{1'b1}}) begin
                                cnt_n = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
            end
            ERR: begin
                state_n = ERR;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Register stage: every output is a flop fed by the next-state logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ecode_q   <= E_NONE;
            exp_q     <= ST_0;
            cnt_q     <= '0;
            armed     <= 1'b0;
            err       <= 1'b0;
            loop_done <= 1'b0;
`ifdef SEQ_TRACE_STUTTER_EN
            prev_q    <= ST_0;
`endif
        end else begin
            state_q   <= state_n;
            ecode_q   <= ecode_n;
            exp_q     <= exp_n;
            cnt_q     <= cnt_n;
            armed     <= (state_n == TRACK);
            err       <= (state_n == ERR);
            loop_done <= done_n;
`ifdef SEQ_TRACE_STUTTER_EN
            prev_q    <= prev_n;
`endif
        end
    end

    assign err_code = ecode_q;
    assign loop_cnt = cnt_q;

endmodule

// File: tb/tb_seq_trace_checker.sv
module tb_seq_trace_checker;

    localparam int CNT_W = 2;
    localparam int VEC_W = CNT_W + 5;
`ifdef SEQ_TRACE_STUTTER_EN
    localparam bit STUTTER = 1'b1;
`else
    localparam bit STUTTER = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_vld = 1'b0;
    logic [2:0]       st_code = 3'd0;
    logic             flag = 1'b0;
    logic             armed;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] loop_cnt;
    logic             loop_done;

    seq_trace_checker #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_vld    (in_vld),
        .st_code   (st_code),
        .flag      (flag),
        .armed     (armed),
        .err       (err),
        .err_code  (err_code),
        .loop_cnt  (loop_cnt),
        .loop_done (loop_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;

    // Reference model: mode 0 idle, 1 tracking, 2 failed.
    int m_mode;
    int m_cause;
    int m_loops;
    bit m_done;
    int m_exp;
    int m_prev;
    int loop_seq [4] = '{0, 2, 6, 3};

    function automatic int pos_in_loop(input int code);
        for (int i = 0; i < 4; i++) if (loop_seq[i] == code) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cause = 0; m_loops = 0; m_done = 0; m_exp = 0; m_prev = 0;
    endtask

    task automatic model_step(input bit v, input int code, input bit f);
        m_done = 0;
        if (!v || m_mode == 2) return;
        if (f) begin
            m_mode = 2; m_cause = 1;
        end else if (m_mode == 0) begin
            if (code == 0) begin m_mode = 1; m_exp = 2; m_prev = 0; end
        end else if (pos_in_loop(code) < 0) begin
            m_mode = 2; m_cause = 2;
        end else if (STUTTER && code == m_prev) begin
            m_done = 0;
        end else if (code != m_exp) begin
            m_mode = 2; m_cause = 3;
        end else begin
            if (code == 0) begin m_loops++; m_done = 1; end
            m_exp  = loop_seq[(pos_in_loop(code) + 1) % 4];
            m_prev = code;
        end
    endtask

    function automatic logic [VEC_W-1:0] model_vec();
        int lim = (1 << CNT_W) - 1;
        int c   = (m_loops > lim) ? lim : m_loops;
        return {m_mode == 1, m_mode == 2, 2'(m_cause), CNT_W'(c), m_done};
    endfunction

    logic [VEC_W-1:0] dut_vec;
    assign dut_vec = {armed, err, err_code, loop_cnt, loop_done};

    // Drive one sample, advance one edge, and update the model.
    task automatic step(input bit r, input bit v, input int code, input bit f);
        reset = r; in_vld = v; st_code = 3'(code); flag = f;
        @(posedge clk);
        #1;
        if (r) model_reset(); else model_step(v, code, f);
        if (dut_vec[0] === 1'b1) n_done++;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        n_chk++;
        if (dut_vec !== '0) $display("FAIL reset: got %b required %b", dut_vec, {VEC_W{1'b0}});
        else n_pass++;
    endtask

    task automatic test_loops();
        int codes [9] = '{0, 2, 6, 3, 0, 2, 6, 3, 0};
        step(1, 0, 0, 0);
        foreach (codes[i]) begin
            step(0, 1, codes[i], 0);
            n_chk++;
            if (dut_vec !== model_vec())
                $display("FAIL loops[%0d]: got %b required %b", i, dut_vec, model_vec());
            else n_pass++;
        end
        n_chk++;
        if (loop_cnt !== 2'd2 || err !== 1'b0)
            $display("FAIL loops_final: got cnt=%0d err=%b required cnt=2 err=0", loop_cnt, err);
        else n_pass++;
    endtask

    task automatic test_seq_err();
        int codes [3] = '{0, 2, 3};
        step(1, 0, 0, 0);
        foreach (codes[i]) step(0, 1, codes[i], 0);
        n_chk++;
        if (err !== 1'b1 || err_code !== 2'd3)
            $display("FAIL seq_err: got err=%b code=%0d required err=1 code=3", err, err_code);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            n_chk++;
            if (dut_vec !== model_vec())
                $display("FAIL seq_err_frozen[%0d]: got %b required %b", i, dut_vec, model_vec());
            else n_pass++;
        end
    endtask

    task automatic test_flag_wins();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 5, 1);
        n_chk++;
        if (err !== 1'b1 || err_code !== 2'd1)
            $display("FAIL flag_wins: got err=%b code=%0d required err=1 code=1", err, err_code);
        else n_pass++;
        for (int i = 0; i < 10; i++) step(0, 0, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        n_chk++;
        if (dut_vec !== model_vec() || err !== 1'b1)
            $display("FAIL flag_hold: got %b required %b", dut_vec, model_vec());
        else n_pass++;
        step(1, 1, 3, 1);
        n_chk++;
        if (dut_vec !== '0) $display("FAIL reset_from_err: got %b required %b", dut_vec, {VEC_W{1'b0}});
        else n_pass++;
    endtask

    task automatic test_idle_ignore();
        int codes [4] = '{6, 5, 3, 0};
        step(1, 0, 0, 0);
        foreach (codes[i]) begin
            step(0, 1, codes[i], 0);
            n_chk++;
            if (dut_vec !== model_vec())
                $display("FAIL idle_ignore[%0d]: got %b required %b", i, dut_vec, model_vec());
            else n_pass++;
        end
        n_chk++;
        if (armed !== 1'b1 || loop_cnt !== '0 || err !== 1'b0)
            $display("FAIL idle_arm: got armed=%b cnt=%0d err=%b required 1 0 0", armed, loop_cnt, err);
        else n_pass++;
    endtask

    task automatic test_saturation();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        n_done = 0;
        for (int l = 0; l < 5; l++) begin
            for (int k = 1; k <= 4; k++) begin
                if ($urandom_range(0, 2) == 0) step(0, 0, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                step(0, 1, loop_seq[k % 4], 0);
                n_chk++;
                if (dut_vec !== model_vec())
                    $display("FAIL sat[%0d.%0d]: got %b required %b", l, k, dut_vec, model_vec());
                else n_pass++;
            end
        end
        n_chk++;
        if (n_done != 5 || loop_cnt !== 2'd3 || err !== 1'b0)
            $display("FAIL sat_final: got pulses=%0d cnt=%0d err=%b required 5 3 0", n_done, loop_cnt, err);
        else n_pass++;
    endtask

    task automatic test_stutter();
        int codes [4] = '{0, 2, 2, 6};
        step(1, 0, 0, 0);
        foreach (codes[i]) begin
            step(0, 1, codes[i], 0);
            n_chk++;
            if (dut_vec !== model_vec())
                $display("FAIL stutter[%0d]: got %b required %b", i, dut_vec, model_vec());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        step(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit r = ($urandom_range(0, 79) == 0);
            bit v = ($urandom_range(0, 4) != 0);
            bit f = ($urandom_range(0, 59) == 0);
            int c;
            if ($urandom_range(0, 9) < 7) c = (m_mode == 1) ? m_exp : 0;
            else if ($urandom_range(0, 1) == 0 && m_mode == 1) c = m_prev;
            else c = int'($urandom_range(0, 7));
            step(r, v, c, f);
            n_chk++;
            if (dut_vec !== model_vec())
                $display("FAIL random[%0d]: got %b required %b", i, dut_vec, model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_loops();
        test_seq_err();
        test_flag_wins();
        test_idle_ignore();
        test_saturation();
        test_stutter();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
